// File: rtl/stream_frame_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_frame_arb_if
// Brief    : Multi-source AXI-Stream bundle feeding one shared stream sink.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_frame_arb_if #(
   parameter int NSRC = 4,
   parameter int DW   = 32
);
   logic [NSRC*DW-1:0]   s_tdata;
   logic [NSRC*DW/8-1:0] s_tkeep;
   logic [NSRC-1:0]      s_tlast;
   logic [NSRC-1:0]      s_tvalid;
   logic [NSRC-1:0]      s_tready;

   logic [DW-1:0]        m_tdata;
   logic [DW/8-1:0]      m_tkeep;
   logic                 m_tlast;
   logic                 m_tvalid;
   logic                 m_tready;

   // master = the arbiter, slave = the surrounding sources and sink
   modport master (
      input  s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
      output s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid
   );

   modport slave (
      output s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
      input  s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid
   );
endinterface
`default_nettype wire

// File: rtl/stream_frame_arb.sv
`default_nettype none
// ============================================================================
// Module   : stream_frame_arb
// Brief    : Frame-locked round-robin arbiter merging NSRC AXI-Stream sources.
// Revision : 1.0 - initial release
// ============================================================================
module stream_frame_arb #(
   parameter int NSRC = 4,
   parameter int DW   = 32,
   parameter int CW   = 16
) (
   input  logic               axi_aclk,
   input  logic               axi_aresetn,
   input  logic [NSRC-1:0]    src_en,
   stream_frame_arb_if.master bus,
   output logic               busy,
   output logic [2:0]         grant_id,
   output logic [NSRC*CW-1:0] frame_cnt
);
   localparam int KW = DW / 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_XFER = 1'b1;

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [2:0]         r_grant_id;
   logic [2:0]         r_last_grant;
   logic [2:0]         w_pick;
   int                 w_best;
   logic [NSRC-1:0]    w_req;
   logic               w_req_any;
   logic               w_accept_last;
   logic [NSRC*CW-1:0] r_frame_cnt;

   assign w_req         = bus.s_tvalid & src_en;
   assign w_req_any     = |w_req;
   assign w_accept_last = (r_state == ST_XFER) & bus.m_tvalid & bus.m_tready & bus.m_tlast;

   // Pick the requester with the smallest circular distance after last_grant
   always_comb begin : p_rr_pick
      w_pick = '0;
      w_best = NSRC;
      for (int c = 0; c < NSRC; c++) begin
         if (w_req[c] && (((c - int'(r_last_grant) - 1 + NSRC) % NSRC) < w_best)) begin
            w_best = (c - int'(r_last_grant) - 1 + NSRC) % NSRC;
            w_pick = 3'(c);
         end
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin : p_state_reg
      if (!axi_aresetn) begin
         r_state      <= ST_IDLE;
         r_grant_id   <= '0;
         r_last_grant <= 3'(NSRC - 1);
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && w_req_any) begin
            r_grant_id   <= w_pick;
            r_last_grant <= w_pick;
         end
      end
   end

   always_comb begin : p_next_state
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_req_any)     w_state_nxt = ST_XFER;
         ST_XFER: if (w_accept_last) w_state_nxt = ST_IDLE;
         default:                    w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin : p_outputs
      bus.m_tdata  = '0;
      bus.m_tkeep  = '0;
      bus.m_tlast  = 1'b0;
      bus.m_tvalid = 1'b0;
      bus.s_tready = '0;
      if (r_state == ST_XFER) begin
         for (int i = 0; i < NSRC; i++) begin
            if (r_grant_id == 3'(i)) begin
               bus.m_tdata     = bus.s_tdata[i*DW +: DW];
               bus.m_tkeep     = bus.s_tkeep[i*KW +: KW];
               bus.m_tlast     = bus.s_tlast[i];
               bus.m_tvalid    = bus.s_tvalid[i];
               bus.s_tready[i] = bus.m_tready;
            end
         end
      end
   end

   // Counters bump on the same edge that takes the tlast beat
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin : p_frame_cnt
      if (!axi_aresetn) begin
         r_frame_cnt <= '0;
      end else if (w_accept_last) begin
         for (int i = 0; i < NSRC; i++) begin
            if (r_grant_id == 3'(i)) begin
               r_frame_cnt[i*CW +: CW] <= r_frame_cnt[i*CW +: CW] + CW'(1);
            end
         end
      end
   end

   assign busy      = (r_state == ST_XFER);
   assign grant_id  = r_grant_id;
   assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
